// File: rtl/rr_group_arbiter_hs.sv
// Round-robin group arbiter with grant/acknowledge handshake: snapshots a request group,
// grants each member once from a rotating start point. Optional forced drop: RR_ARB_TIMEOUT_EN.
module rr_group_arbiter_hs #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              refresh_i,
  input  logic [N_REQ-1:0]  req_i,
  input  logic              gnt_ack_i,
  output logic [N_REQ-1:0]  gnt_o,
  output logic              gnt_valid_o,
  output logic [ADDR_W-1:0] xadd_o,
  output logic              grp_release_o,
  output logic              busy_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t            state, state_next;
  logic [N_REQ-1:0]  pend, pend_next;
  logic [N_REQ-1:0]  gnt, gnt_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic [ADDR_W-1:0] xadd, xadd_next;
  logic              gnt_valid, gnt_valid_next;
  logic              release_q, release_next;

  logic [N_REQ-1:0]  kept, rest;
  logic [ADDR_W-1:0] next_ptr, pick_idx;
  logic              drained, accept, expire;

  // First set bit of vec at or above start, wrapping past the top channel.
  function automatic logic [ADDR_W-1:0] find_next(input logic [N_REQ-1:0] vec,
                                                  input logic [ADDR_W-1:0] start);
    logic [ADDR_W-1:0] result;
    logic [N_REQ-1:0]  shifted;
    logic              found;
    int                pos;
    result = '0;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      pos     = (int'(start) + k) % N_REQ;
      shifted = vec >> pos;
      if (!found && shifted[0]) begin
        found  = 1'b1;
        result = ADDR_W'(pos);
      end
    end
    return result;
  endfunction

  function automatic logic [N_REQ-1:0] to_onehot(input logic [ADDR_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] idx);
    return (int'(idx) + 1 >= N_REQ) ? '0 : ADDR_W'(int'(idx) + 1);
  endfunction

  // The granted bit survives a withdrawn request; it only leaves on acceptance.
  assign kept     = pend & (req_i | gnt);
  assign rest     = kept & ~gnt;
  assign drained  = ~|(pend & req_i);
  assign next_ptr = wrap_inc(xadd);
  assign pick_idx = (state == IDLE) ? find_next(req_i, ptr) : find_next(rest, next_ptr);
  assign accept   = gnt_ack_i | expire;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;

  assign expire    = (state == GRANT) && !gnt_ack_i && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign timeout_o = expire && enable_i && !reset_i && !refresh_i;

  always_comb begin
    wait_cnt_next = wait_cnt;
    if (enable_i) begin
      if (state == GRANT && !accept && !drained)
        wait_cnt_next = wait_cnt + CNT_W'(1);
      else
        wait_cnt_next = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || refresh_i)
      wait_cnt <= '0;
    else
      wait_cnt <= wait_cnt_next;
  end
`else
  assign expire    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_next     = state;
    pend_next      = pend;
    gnt_next       = gnt;
    ptr_next       = ptr;
    xadd_next      = xadd;
    gnt_valid_next = gnt_valid;
    release_next   = release_q;
    if (enable_i) begin
      case (state)
        IDLE: begin
          release_next = 1'b0;
          if (|req_i) begin
            pend_next      = req_i;
            gnt_next       = to_onehot(pick_idx);
            xadd_next      = pick_idx;
            gnt_valid_next = 1'b1;
            state_next     = GRANT;
          end
        end
        GRANT: begin
          if (accept) begin
            ptr_next = next_ptr;
            if (|rest) begin
              pend_next = rest;
              gnt_next  = to_onehot(pick_idx);
              xadd_next = pick_idx;
            end else begin
              pend_next      = '0;
              gnt_next       = '0;
              gnt_valid_next = 1'b0;
              release_next   = 1'b1;
              state_next     = RELEASE;
            end
          end else if (drained) begin
            pend_next      = '0;
            gnt_next       = '0;
            gnt_valid_next = 1'b0;
            release_next   = 1'b1;
            state_next     = RELEASE;
          end else begin
            pend_next = kept;
          end
        end
        RELEASE: begin
          release_next = 1'b0;
          state_next   = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Refresh aborts the group exactly like reset, without a release pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i || refresh_i) begin
      state     <= IDLE;
      pend      <= '0;
      gnt       <= '0;
      ptr       <= '0;
      xadd      <= '0;
      gnt_valid <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state     <= state_next;
      pend      <= pend_next;
      gnt       <= gnt_next;
      ptr       <= ptr_next;
      xadd      <= xadd_next;
      gnt_valid <= gnt_valid_next;
      release_q <= release_next;
    end
  end

  assign gnt_o         = gnt;
  assign gnt_valid_o   = gnt_valid;
  assign xadd_o        = xadd;
  assign grp_release_o = release_q;
  assign busy_o        = (state != IDLE);

endmodule
